voice_mixer: RTL and testbench
==============================

# voice_mixer

Time-multiplexed mixing stage directly downstream of the per-voice AD envelope generators. On each `sample_tick` it snapshots every voice's signed oscillator sample and 8-bit envelope, then multiplies and accumulates one voice per clock. The sum is scaled, saturated and converted to offset-binary 8-bit for the PWM/DAC output stage. One shared multiplier serves all voices.

## Interface
- `VOICES`, default 4: number of voices mixed; legal range 1–16.
- `GAIN_SHIFT`, default 8: arithmetic right shift applied to the accumulated sum before saturation.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, synchronous, active-low.
- `sample_tick  in  1`: one-cycle strobe that starts a mix.
- `wave_in  in  VOICES*8`: voice i in bits [8i+7:8i], two's-complement sample.
- `env_in  in  VOICES*8`: voice i in bits [8i+7:8i], unsigned envelope from the envelope generator.
- `audio_out  out  8`: offset-binary mixed sample; 0x80 is silence; held between updates.
- `out_valid  out  1`: one-cycle pulse when `audio_out` updates.
- `busy  out  1`: high from the snapshot cycle through the output cycle.
- `overrun  out  1`: sticky; set when `sample_tick` arrives while busy; cleared only by reset.

## Operation
- States:
  - IDLE: waits for `sample_tick`.
  - MAC: accumulates one voice per cycle, index 0 to `VOICES-1`.
  - OUT: scales, saturates and registers the result.
- Transitions:
  - IDLE with `sample_tick`: capture all of `wave_in` and `env_in` into snapshot registers, clear the accumulator and the index, go to MAC.
  - MAC: add product(idx) to the accumulator and increment idx. After idx = `VOICES-1`, go to OUT.
  - OUT: write `audio_out`, pulse `out_valid`, return to IDLE.
- Product: signed wave × zero-extended env. The result is 17-bit signed, range -32640..32385.
- Accumulator width is 17+clog2(`VOICES`) bits (minimum 17), signed, and cannot overflow.
- Scaling: the accumulator is shifted arithmetically right by `GAIN_SHIFT`, which floors toward minus infinity.
- Saturation: clamp to the range [-128, 127].
- Output conversion: invert the MSB of the clamped value to form `audio_out`.
- Input changes after the snapshot have no effect on the mix in progress.
- `sample_tick` while not in IDLE:
  - Ignored, and sets `overrun`.
  - The current mix completes normally.
  - No second mix is queued.
- A `sample_tick` that arrives in the same cycle as OUT is also an overrun.

## Timing
- Reset values:
  - `audio_out` = 0x80.
  - `out_valid` = 0, `busy` = 0, `overrun` = 0.
  - State IDLE, accumulator and index cleared.
- Reset is synchronous and has priority over all events. Reset during MAC or OUT aborts the mix: no `out_valid` pulse, and `audio_out` returns to 0x80.
- Latency: `sample_tick` is high in cycle T. Snapshot at edge T, MAC in cycles T+1..T+VOICES, OUT edge at the end of T+VOICES+1. `out_valid` and the new `audio_out` are therefore visible in cycle T+VOICES+2.
- `busy` is high in cycles T+1..T+VOICES+1.
- Minimum `sample_tick` spacing without overrun: VOICES+2 cycles.
- `out_valid` is never high for two consecutive cycles.

## Structure
- Shared package `synth_pkg` holds:
  - The state enum (IDLE, MAC, OUT).
  - The constant `SILENCE_U8` = 8'h80.
  - An `acc_width(voices)` function, also used by future multi-voice blocks.
- One sub-module, `sat_s_to_u8`. It is combinational and parameterised by input width: arithmetic shift, clamp, MSB flip. It is reused by the filter stage.
- The multiply, accumulate and FSM stay in `voice_mixer`. Voice selection is a mux on the registered index.

## Test plan
- After reset, with `VOICES`=4 and `GAIN_SHIFT`=8, a tick with all envelopes 0 -> `audio_out`=0x80 and `out_valid` pulses exactly 6 cycles after the tick.
- Voice0 wave=+127, env=255, others env=0 -> `audio_out`=0xFE. Voice0 wave=-128, env=255 -> 0x00, confirming floor rounding of -127.5 to -128.
- All four voices wave=+127, env=255 -> sum 129540 saturates to 0xFF. All four wave=-128, env=255 -> 0x00.
- Second tick 3 cycles after the first -> `overrun`=1, exactly one `out_valid`, and output equals the first mix. `overrun` stays 1 until reset.
- `wave_in` and `env_in` changed during MAC cycles -> output matches the snapshot values.
- Reset asserted during MAC -> no `out_valid`, `audio_out`=0x80 and `busy`=0 next cycle. A fresh tick afterwards mixes correctly.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice path: mixer FSM states, output
// silence code and accumulator sizing used by multi-voice blocks.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } mix_state_t;

    localparam logic [7:0] SILENCE_U8 = 8'h80;

    // Full-scale product is 17 bits signed; each doubling of voices needs one guard bit.
    function automatic int acc_width(input int voices);
        return 32'sd17 + $clog2(voices);
    endfunction

endpackage

// File: rtl/sat_s_to_u8.sv
// Signed-to-offset-binary output stage: arithmetic shift (floors), clamp to
// [-128,127], then flip the MSB so that 0 maps to 0x80.
module sat_s_to_u8 #(
    parameter int IN_W  = 17,
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0] din,
    output logic        [7:0]      dout
);

    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-8){1'b0}}, 8'h7F};
    localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-8){1'b1}}, 8'h80};

    logic signed [IN_W-1:0] shifted_s;
    logic signed [7:0]      clamped_s;

    // Scale, saturate and convert to offset binary.
    always_comb begin
        shifted_s = din >>> SHIFT;
        if (shifted_s > SAT_MAX) begin
            clamped_s = 8'sh7F;
        end else if (shifted_s < SAT_MIN) begin
            clamped_s = -8'sd128;
        end else begin
            clamped_s = shifted_s[7:0];
        end
        dout = {~clamped_s[7], clamped_s[6:0]};
    end

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed voice mixer: snapshots all voices on sample_tick, then runs
// one shared signed x unsigned multiply-accumulate per clock.
module voice_mixer
    import synth_pkg::*;
#(
    parameter int VOICES     = 4,
    parameter int GAIN_SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic [VOICES*8-1:0]   wave_in,
    input  logic [VOICES*8-1:0]   env_in,
    output logic [7:0]            audio_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int ACC_W = acc_width(VOICES);
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VOICES - 1);

    mix_state_t               state_r, state_s;
    logic [VOICES*8-1:0]      wave_r, env_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [IDX_W-1:0]         idx_r;
    logic                     snap_s, mac_s, out_s, ovr_s;
    logic [7:0]               wave_sel_s, env_sel_s;
    logic signed [16:0]       wave_ext_s, env_ext_s, prod_s;
    logic [7:0]               sat_u8_s;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_s = state_r;
        snap_s  = 1'b0;
        mac_s   = 1'b0;
        out_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (sample_tick) begin
                    snap_s  = 1'b1;
                    state_s = MAC;
                end else begin
                    state_s = IDLE;
                end
            end
            MAC: begin
                mac_s = 1'b1;
                if (idx_r == IDX_LAST) begin
                    state_s = OUT;
                end else begin
                    state_s = MAC;
                end
            end
            OUT: begin
                out_s   = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // A tick is only accepted in IDLE; anywhere else it is lost.
        ovr_s = sample_tick && (state_r != IDLE);
    end

    // Voice select from the snapshot on the registered index, then one multiply.
    always_comb begin
        wave_sel_s = 8'h00;
        env_sel_s  = 8'h00;
        for (int i = 0; i < VOICES; i++) begin
            if (idx_r == IDX_W'(i)) begin
                wave_sel_s = wave_r[i*8 +: 8];
                env_sel_s  = env_r[i*8 +: 8];
            end else begin
            end
        end
        wave_ext_s = {{9{wave_sel_s[7]}}, wave_sel_s};
        env_ext_s  = {9'b0_0000_0000, env_sel_s};
        prod_s     = wave_ext_s * env_ext_s;
    end

    sat_s_to_u8 #(
        .IN_W  (ACC_W),
        .SHIFT (GAIN_SHIFT)
    ) u_sat (
        .din  (acc_r),
        .dout (sat_u8_s)
    );

    // Snapshot, accumulator, index and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wave_r    <= '0;
            env_r     <= '0;
            acc_r     <= '0;
            idx_r     <= '0;
            audio_out <= SILENCE_U8;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (snap_s) begin
                wave_r <= wave_in;
                env_r  <= env_in;
                acc_r  <= '0;
                idx_r  <= '0;
            end else if (mac_s) begin
                acc_r <= acc_r + ACC_W'(prod_s);
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                acc_r <= acc_r;
                idx_r <= idx_r;
            end
            if (out_s) begin
                audio_out <= sat_u8_s;
            end else begin
                audio_out <= audio_out;
            end
            out_valid <= out_s;
            busy      <= (state_s != IDLE);
            overrun   <= overrun | ovr_s;
        end
    end

endmodule

// File: tb/tb_voice_mixer.sv
// Randomised scoreboard bench for voice_mixer (4 voices, shift 8) with
// directed saturation, overrun, snapshot and mid-mix reset cases.
module tb_voice_mixer;

    localparam int VOICES     = 4;
    localparam int GAIN_SHIFT = 8;
    localparam int LAT        = VOICES + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic [31:0] wave_in, env_in;
    logic [7:0]  audio_out;
    logic        out_valid, busy, overrun;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] audio;
        int         due;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    logic prev_valid = 1'b0;

    voice_mixer #(
        .VOICES     (VOICES),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .wave_in     (wave_in),
        .env_in      (env_in),
        .audio_out   (audio_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference mix: integer sum, floor division by 2^GAIN_SHIFT, clamp, re-bias.
    function automatic logic [7:0] model(input logic [31:0] w, input logic [31:0] e);
        int sum, q, den, wv, ev;
        logic [7:0] wb;
        sum = 0;
        den = 1 << GAIN_SHIFT;
        for (int i = 0; i < VOICES; i++) begin
            wb  = w[i*8 +: 8];
            wv  = (wb >= 8'd128) ? int'(wb) - 256 : int'(wb);
            ev  = int'(e[i*8 +: 8]);
            sum = sum + wv * ev;
        end
        q = sum / den;
        if (sum < 0 && (sum % den) != 0) q = q - 1;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return 8'(q + 128);
    endfunction

    // Monitor: every out_valid must match the oldest expected mix, on time.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            check("out_valid_back_to_back", {31'd0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 audio=%0h, required no pulse (cycle %0d)",
                         audio_out, cyc);
            end else begin
                e_m = sb.pop_front();
                check("audio_out", {24'd0, audio_out}, {24'd0, e_m.audio});
                check("out_valid_latency", cyc, e_m.due);
            end
        end
        prev_valid = out_valid;
    end

    task automatic do_tick(input logic [31:0] w, input logic [31:0] e, input bit expect_out);
        exp_t x;
        wave_in     = w;
        env_in      = e;
        sample_tick = 1'b1;
        if (expect_out) begin
            x.audio = model(w, e);
            x.due   = cyc + LAT;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending outputs, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w, e, wa, ea;
        rst         = 1'b0;
        sample_tick = 1'b0;
        wave_in     = 32'd0;
        env_in      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_audio", {24'd0, audio_out}, 32'h80);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // All envelopes zero: silence.
        do_tick($urandom(), 32'd0, 1'b1);
        check("busy_after_tick", {31'd0, busy}, 32'd1);
        drain();
        check("silence", {24'd0, audio_out}, 32'h80);

        // Single voice extremes and all-voice saturation.
        do_tick(32'h0000_007F, 32'h0000_00FF, 1'b1);
        drain();
        check("v0_pos_full", {24'd0, audio_out}, 32'hFE);
        do_tick(32'h0000_0080, 32'h0000_00FF, 1'b1);
        drain();
        check("v0_neg_floor", {24'd0, audio_out}, 32'h00);
        do_tick(32'h7F7F_7F7F, 32'hFFFF_FFFF, 1'b1);
        drain();
        check("sat_pos", {24'd0, audio_out}, 32'hFF);
        do_tick(32'h8080_8080, 32'hFFFF_FFFF, 1'b1);
        drain();
        check("sat_neg", {24'd0, audio_out}, 32'h00);
        check("busy_idle", {31'd0, busy}, 32'd0);

        // Back-to-back random mixes at or above the minimum tick spacing.
        for (int n = 0; n < 40; n++) begin
            w = $urandom();
            e = $urandom();
            if ($urandom_range(0, 3) == 0) e = 32'hFFFF_FFFF;
            do_tick(w, e, 1'b1);
            repeat (VOICES + $urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        drain();
        check("no_overrun_at_min_spacing", {31'd0, overrun}, 32'd0);

        // Inputs scrambled during MAC must not disturb the snapshot.
        do_tick($urandom(), $urandom(), 1'b1);
        for (int n = 0; n < VOICES; n++) begin
            wave_in = $urandom();
            env_in  = $urandom();
            @(posedge clk);
            #1;
        end
        drain();

        // Early second tick: ignored, flagged, first mix completes alone.
        wa = 32'h0000_007F;
        ea = 32'h0000_00FF;
        do_tick(wa, ea, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("busy_mid_mix", {31'd0, busy}, 32'd1);
        do_tick(32'h8080_8080, 32'hFFFF_FFFF, 1'b0);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        drain();
        repeat (10) @(posedge clk);
        #1;
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        check("overrun_out_is_first", {24'd0, audio_out}, 32'hFE);

        // Reset in the middle of a mix aborts it.
        do_tick(32'h8080_8080, 32'hFFFF_FFFF, 1'b0);
        check("busy_before_abort", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_audio", {24'd0, audio_out}, 32'h80);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_overrun_cleared", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_audio_held", {24'd0, audio_out}, 32'h80);

        // Fresh mix after the abort.
        do_tick($urandom(), $urandom(), 1'b1);
        drain();
        check("final_overrun", {31'd0, overrun}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
